// File: rtl/cp_fetch_scheduler_if.sv
// Handshake bundle between the command-processor main FSM / DDR read port and
// the fetch scheduler. The master side drives requests, the slave side is the scheduler.
interface cp_fetch_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int BLEN_W = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [3:0]        Main_FSM_state;
  logic [NUM_CH-1:0] event_fifo_empty;
  logic [BLEN_W-1:0] burst_len_cfg;
  logic              rd_beat;
  logic              RD_Done;
  logic              err_clr;

  logic              rd_req;
  logic [CH_W-1:0]   rd_ch;
  logic [BLEN_W-1:0] rd_len;
  logic [BLEN_W-1:0] beat_cnt;
  logic              CP_IN_WAIT;
  logic              CP_IN_Check_Empty;
  logic              CP_IN_DDR_PRE;
  logic              CP_IN_DDR_READ;
  logic              CP_IN_DDR_READ_Finish;
  logic              CP_IN_ERR;
  logic              timeout_err;
  logic              len_err;

  modport master (
    output Main_FSM_state, event_fifo_empty, burst_len_cfg, rd_beat, RD_Done, err_clr,
    input  rd_req, rd_ch, rd_len, beat_cnt,
    input  CP_IN_WAIT, CP_IN_Check_Empty, CP_IN_DDR_PRE, CP_IN_DDR_READ,
    input  CP_IN_DDR_READ_Finish, CP_IN_ERR, timeout_err, len_err
  );

  modport slave (
    input  Main_FSM_state, event_fifo_empty, burst_len_cfg, rd_beat, RD_Done, err_clr,
    output rd_req, rd_ch, rd_len, beat_cnt,
    output CP_IN_WAIT, CP_IN_Check_Empty, CP_IN_DDR_PRE, CP_IN_DDR_READ,
    output CP_IN_DDR_READ_Finish, CP_IN_ERR, timeout_err, len_err
  );
endinterface

// File: rtl/cp_fetch_scheduler.sv
// Round-robin fetch scheduler: picks a non-empty event FIFO channel, issues one
// DDR burst read, counts returned beats and flags length mismatches and timeouts.
module cp_fetch_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int BLEN_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              RST_N,
  cp_fetch_scheduler_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_CHECK  = 3'd1,
    S_PRE    = 3'd2,
    S_READ   = 3'd3,
    S_FINISH = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t            state_reg;
  logic [CH_W-1:0]   last_grant_reg;
  logic              rd_req_reg;
  logic [CH_W-1:0]   rd_ch_reg;
  logic [BLEN_W-1:0] rd_len_reg;
  logic [BLEN_W-1:0] beat_cnt_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              timeout_err_reg;
  logic              len_err_reg;

  logic              any_ready;
  logic [CH_W-1:0]   grant;
  logic [BLEN_W-1:0] beat_next;
  logic              len_err_set;
  logic              timeout_err_set;
  logic              to_expired;

  // First non-empty channel searching upward from last+1, wrapping modulo NUM_CH.
  // Offsets are scanned from the far end so the nearest candidate is the one kept.
  function automatic logic [CH_W-1:0] rr_pick(input logic [CH_W-1:0] last,
                                               input logic [NUM_CH-1:0] empty);
    logic [CH_W:0]   sum_v;
    logic [CH_W-1:0] pick_v;
    pick_v = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      sum_v = {1'b0, last} + (CH_W+1)'(off);
      if (sum_v >= (CH_W+1)'(NUM_CH))
        sum_v = sum_v - (CH_W+1)'(NUM_CH);
      if (!empty[sum_v[CH_W-1:0]])
        pick_v = sum_v[CH_W-1:0];
    end
    return pick_v;
  endfunction

  assign any_ready       = ~&bus.event_fifo_empty;
  assign grant           = rr_pick(last_grant_reg, bus.event_fifo_empty);
  assign beat_next       = (bus.rd_beat && (beat_cnt_reg != '1)) ? beat_cnt_reg + BLEN_W'(1)
                                                                 : beat_cnt_reg;
  assign to_expired      = (to_cnt_reg == TO_W'(TIMEOUT - 1));
  assign len_err_set     = (state_reg == S_READ) && bus.RD_Done && (beat_next != rd_len_reg);
  assign timeout_err_set = (state_reg == S_READ) && !bus.RD_Done && to_expired;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg       <= S_WAIT;
      last_grant_reg  <= CH_W'(NUM_CH - 1);
      rd_req_reg      <= 1'b0;
      rd_ch_reg       <= '0;
      rd_len_reg      <= '0;
      beat_cnt_reg    <= '0;
      to_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
      len_err_reg     <= 1'b0;
    end else begin
      rd_req_reg      <= 1'b0;
      // A set event in the same cycle as err_clr leaves the flag set.
      timeout_err_reg <= timeout_err_set | (timeout_err_reg & ~bus.err_clr);
      len_err_reg     <= len_err_set     | (len_err_reg     & ~bus.err_clr);

      case (state_reg)
        S_WAIT: begin
          if (bus.Main_FSM_state == 4'd2)
            state_reg <= S_CHECK;
        end
        S_CHECK: begin
          if (any_ready) begin
            state_reg      <= S_PRE;
            rd_req_reg     <= 1'b1;
            rd_ch_reg      <= grant;
            last_grant_reg <= grant;
            rd_len_reg     <= (bus.burst_len_cfg == '0) ? BLEN_W'(1) : bus.burst_len_cfg;
            beat_cnt_reg   <= '0;
            to_cnt_reg     <= '0;
          end else if (bus.Main_FSM_state == 4'd0) begin
            state_reg <= S_WAIT;
          end
        end
        S_PRE: begin
          state_reg <= S_READ;
        end
        S_READ: begin
          beat_cnt_reg <= beat_next;
          to_cnt_reg   <= to_cnt_reg + TO_W'(1);
          if (bus.RD_Done)
            state_reg <= S_FINISH;
          else if (to_expired)
            state_reg <= S_ERR;
        end
        S_FINISH: begin
          if (bus.Main_FSM_state == 4'd3)
            state_reg <= S_CHECK;
          else if (bus.Main_FSM_state == 4'd0)
            state_reg <= S_WAIT;
        end
        S_ERR: begin
          if (bus.err_clr)
            state_reg <= S_WAIT;
        end
        default: begin
          state_reg <= S_WAIT;
        end
      endcase
    end
  end

  assign bus.rd_req      = rd_req_reg;
  assign bus.rd_ch       = rd_ch_reg;
  assign bus.rd_len      = rd_len_reg;
  assign bus.beat_cnt    = beat_cnt_reg;
  assign bus.timeout_err = timeout_err_reg;
  assign bus.len_err     = len_err_reg;

  // Illegal encodings report as WAIT so exactly one flag is always high.
  assign bus.CP_IN_Check_Empty     = (state_reg == S_CHECK);
  assign bus.CP_IN_DDR_PRE         = (state_reg == S_PRE);
  assign bus.CP_IN_DDR_READ        = (state_reg == S_READ);
  assign bus.CP_IN_DDR_READ_Finish = (state_reg == S_FINISH);
  assign bus.CP_IN_ERR             = (state_reg == S_ERR);
  assign bus.CP_IN_WAIT            = !(bus.CP_IN_Check_Empty | bus.CP_IN_DDR_PRE |
                                       bus.CP_IN_DDR_READ | bus.CP_IN_DDR_READ_Finish |
                                       bus.CP_IN_ERR);
endmodule

// File: tb/tb_cp_fetch_scheduler.sv
// Bench for cp_fetch_scheduler: vector table, directed corner sequences and
// random traffic, all checked against a transaction-level reference model.
module tb_cp_fetch_scheduler;
  localparam int NUM_CH  = 4;
  localparam int BLEN_W  = 8;
  localparam int TIMEOUT = 16;

  localparam int ST_WAIT = 0, ST_CHECK = 1, ST_PRE = 2, ST_READ = 3, ST_FIN = 4, ST_ERR = 5;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  cp_fetch_scheduler_if #(.NUM_CH(NUM_CH), .BLEN_W(BLEN_W)) bus();

  cp_fetch_scheduler #(.NUM_CH(NUM_CH), .BLEN_W(BLEN_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase of the current fetch plus its bookkeeping.
  int m_st, m_last, m_ch, m_len, m_bc, m_cyc;
  bit m_req, m_terr, m_lerr;

  typedef struct {
    logic [3:0] main;
    logic [3:0] empty;
    logic [7:0] cfg;
    logic       beat;
    logic       done;
    logic       clr;
    int         st;
    logic       req;
    int         ch;
    int         len;
    int         bc;
    logic       lerr;
    logic       terr;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return 32'({bus.CP_IN_ERR, bus.CP_IN_DDR_READ_Finish, bus.CP_IN_DDR_READ,
                bus.CP_IN_DDR_PRE, bus.CP_IN_Check_Empty, bus.CP_IN_WAIT});
  endfunction

  task automatic model_reset();
    m_st = ST_WAIT; m_last = NUM_CH - 1; m_ch = 0; m_len = 0; m_bc = 0; m_cyc = 0;
    m_req = 0; m_terr = 0; m_lerr = 0;
  endtask

  task automatic model_clock(input logic [3:0] main, input logic [NUM_CH-1:0] empty,
                             input logic [7:0] cfg, input logic beat, input logic done,
                             input logic clr);
    int  nxt;
    int  total;
    bit  tset, lset, found;
    nxt = m_st; tset = 0; lset = 0;
    case (m_st)
      ST_WAIT:  if (main == 4'd2) nxt = ST_CHECK;
      ST_CHECK: begin
        if (empty != '1) begin
          found = 0;
          for (int off = 1; off <= NUM_CH; off++) begin
            int c;
            c = (m_last + off) % NUM_CH;
            if (!found && !empty[c]) begin
              m_ch = c;
              found = 1;
            end
          end
          m_last = m_ch;
          m_len  = (cfg == 0) ? 1 : int'(cfg);
          m_bc   = 0;
          m_cyc  = 0;
          nxt    = ST_PRE;
        end else if (main == 4'd0) begin
          nxt = ST_WAIT;
        end
      end
      ST_PRE: nxt = ST_READ;
      ST_READ: begin
        total = m_bc + int'(beat);
        if (total > 255) total = 255;
        m_bc = total;
        if (done) begin
          nxt = ST_FIN;
          if (total != m_len) lset = 1;
          $display("fetch ch=%0d len=%0d beats=%0d done", m_ch, m_len, total);
        end else if (m_cyc == TIMEOUT - 1) begin
          nxt  = ST_ERR;
          tset = 1;
          $display("fetch ch=%0d len=%0d beats=%0d timeout", m_ch, m_len, total);
        end
        m_cyc++;
      end
      ST_FIN: begin
        if (main == 4'd3)      nxt = ST_CHECK;
        else if (main == 4'd0) nxt = ST_WAIT;
      end
      ST_ERR: if (clr) nxt = ST_WAIT;
      default: nxt = ST_WAIT;
    endcase
    if (clr) begin m_terr = 0; m_lerr = 0; end
    if (tset) m_terr = 1;
    if (lset) m_lerr = 1;
    m_req = (nxt == ST_PRE);
    m_st  = nxt;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".state"},  flags_now(), 32'(1) << m_st);
    check({tag, ".rd_req"}, 32'(bus.rd_req), 32'(m_req));
    check({tag, ".rd_ch"},  32'(bus.rd_ch), 32'(m_ch));
    check({tag, ".rd_len"}, 32'(bus.rd_len), 32'(m_len));
    check({tag, ".beat"},   32'(bus.beat_cnt), 32'(m_bc));
    check({tag, ".terr"},   32'(bus.timeout_err), 32'(m_terr));
    check({tag, ".lerr"},   32'(bus.len_err), 32'(m_lerr));
  endtask

  task automatic drive(input logic [3:0] main, input logic [NUM_CH-1:0] empty,
                       input logic [7:0] cfg, input logic beat, input logic done,
                       input logic clr);
    bus.Main_FSM_state   = main;
    bus.event_fifo_empty = empty;
    bus.burst_len_cfg    = cfg;
    bus.rd_beat          = beat;
    bus.RD_Done          = done;
    bus.err_clr          = clr;
  endtask

  task automatic step(input string tag, input logic [3:0] main, input logic [NUM_CH-1:0] empty,
                      input logic [7:0] cfg, input logic beat, input logic done,
                      input logic clr);
    drive(main, empty, cfg, beat, done, clr);
    @(posedge CLK);
    model_clock(main, empty, cfg, beat, done, clr);
    #1;
    compare_all(tag);
  endtask

  // Reset asserts wherever we are in the cycle; outputs must drop before any edge.
  task automatic do_reset(input string tag);
    drive(4'd1, '1, 8'd0, 1'b0, 1'b0, 1'b0);
    RST_N = 1'b0;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(posedge CLK);
    #1;
    compare_all({tag, ".held"});
    RST_N = 1'b1;
  endtask

  // From CHECK: grant, PRE, READ, nbeats beats, then RD_Done.
  task automatic fetch(input string tag, input logic [3:0] main, input logic [NUM_CH-1:0] empty,
                       input logic [7:0] cfg, input int nbeats, input int exp_ch);
    step({tag, ".pre"}, main, empty, cfg, 0, 0, 0);
    check({tag, ".grant"}, 32'(bus.rd_ch), 32'(exp_ch));
    check({tag, ".req"}, 32'(bus.rd_req), 32'd1);
    step({tag, ".rd0"}, main, empty, cfg, 0, 0, 0);
    for (int b = 0; b < nbeats; b++) step({tag, ".beat"}, main, empty, cfg, 1, 0, 0);
    step({tag, ".done"}, main, empty, cfg, 0, 1, 0);
    check({tag, ".fin"}, 32'(bus.CP_IN_DDR_READ_Finish), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    //        main  empty    cfg   bt dn cl  st        rq ch len bc le te
    vt[0]  = '{4'd2, 4'b1010, 8'd4, 0, 0, 0, ST_CHECK, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{4'd1, 4'b1010, 8'd4, 0, 0, 0, ST_PRE,   1, 0, 4, 0, 0, 0};
    vt[2]  = '{4'd0, 4'b1010, 8'd4, 0, 0, 0, ST_READ,  0, 0, 4, 0, 0, 0};
    vt[3]  = '{4'd0, 4'b1010, 8'd4, 1, 0, 0, ST_READ,  0, 0, 4, 1, 0, 0};
    vt[4]  = '{4'd1, 4'b1010, 8'd4, 1, 0, 0, ST_READ,  0, 0, 4, 2, 0, 0};
    vt[5]  = '{4'd1, 4'b1010, 8'd4, 1, 0, 0, ST_READ,  0, 0, 4, 3, 0, 0};
    vt[6]  = '{4'd1, 4'b1010, 8'd4, 1, 1, 0, ST_FIN,   0, 0, 4, 4, 0, 0};
    vt[7]  = '{4'd1, 4'b1010, 8'd4, 0, 0, 0, ST_FIN,   0, 0, 4, 4, 0, 0};
    vt[8]  = '{4'd3, 4'b1111, 8'd4, 0, 0, 0, ST_CHECK, 0, 0, 4, 4, 0, 0};
    vt[9]  = '{4'd1, 4'b1111, 8'd4, 0, 0, 0, ST_CHECK, 0, 0, 4, 4, 0, 0};
    vt[10] = '{4'd0, 4'b1011, 8'd4, 0, 0, 0, ST_PRE,   1, 2, 4, 0, 0, 0};
    vt[11] = '{4'd1, 4'b1011, 8'd4, 0, 0, 0, ST_READ,  0, 2, 4, 0, 0, 0};
    vt[12] = '{4'd1, 4'b1011, 8'd4, 0, 1, 0, ST_FIN,   0, 2, 4, 0, 1, 0};
    vt[13] = '{4'd0, 4'b1011, 8'd4, 0, 0, 0, ST_WAIT,  0, 2, 4, 0, 1, 0};
    vt[14] = '{4'd1, 4'b1011, 8'd4, 0, 0, 1, ST_WAIT,  0, 2, 4, 0, 0, 0};

    do_reset("rst0");
    for (int i = 0; i < 15; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(t, vt[i].main, vt[i].empty, vt[i].cfg, vt[i].beat, vt[i].done, vt[i].clr);
      check({t, ".tstate"}, flags_now(), 32'(1) << vt[i].st);
      check({t, ".treq"},   32'(bus.rd_req), 32'(vt[i].req));
      check({t, ".tch"},    32'(bus.rd_ch), 32'(vt[i].ch));
      check({t, ".tlen"},   32'(bus.rd_len), 32'(vt[i].len));
      check({t, ".tbeat"},  32'(bus.beat_cnt), 32'(vt[i].bc));
      check({t, ".tlerr"},  32'(bus.len_err), 32'(vt[i].lerr));
      check({t, ".tterr"},  32'(bus.timeout_err), 32'(vt[i].terr));
    end

    // Round robin over three back-to-back fetches with every channel ready.
    do_reset("rst1");
    step("rr.go", 4'd2, 4'b0000, 8'd2, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      fetch($sformatf("rr%0d", k), 4'd1, 4'b0000, 8'd2, 2, k);
      check("rr.lerr", 32'(bus.len_err), 32'd0);
      step("rr.adv", 4'd3, 4'b0000, 8'd2, 0, 0, 0);
    end

    // Zero burst length rounds up to one; extra beats leave a sticky len_err.
    do_reset("rst2");
    step("len0.go", 4'd2, 4'b0000, 8'd0, 0, 0, 0);
    fetch("len0", 4'd1, 4'b0000, 8'd0, 3, 0);
    check("len0.rd_len", 32'(bus.rd_len), 32'd1);
    check("len0.lerr", 32'(bus.len_err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step("len0.hold", 4'd0, 4'b1111, 8'd0, 0, 0, 0);
      check("len0.sticky", 32'(bus.len_err), 32'd1);
    end
    step("len0.clr", 4'd1, 4'b1111, 8'd0, 0, 0, 1);
    check("len0.cleared", 32'(bus.len_err), 32'd0);

    // No RD_Done: ERR must appear exactly TIMEOUT cycles after READ entry.
    do_reset("rst3");
    step("to.go", 4'd2, 4'b1110, 8'd3, 0, 0, 0);
    step("to.pre", 4'd1, 4'b1110, 8'd3, 0, 0, 0);
    step("to.rd0", 4'd1, 4'b1110, 8'd3, 0, 0, 0);
    n = 0;
    while (n < 40 && !bus.CP_IN_ERR) begin
      n++;
      step("to.wait", 4'd1, 4'b1110, 8'd3, 1, 0, 0);
    end
    check("to.cycles", 32'(n), 32'(TIMEOUT));
    check("to.terr", 32'(bus.timeout_err), 32'd1);
    step("to.hold", 4'd2, 4'b0000, 8'd3, 0, 0, 0);
    check("to.inerr", 32'(bus.CP_IN_ERR), 32'd1);
    step("to.clr", 4'd2, 4'b0000, 8'd3, 0, 0, 1);
    check("to.wait_st", 32'(bus.CP_IN_WAIT), 32'd1);
    check("to.terr_clr", 32'(bus.timeout_err), 32'd0);

    // RD_Done on the very cycle the timeout would fire takes precedence.
    do_reset("rst4");
    step("race.go", 4'd2, 4'b0000, 8'd1, 0, 0, 0);
    step("race.pre", 4'd1, 4'b0000, 8'd1, 0, 0, 0);
    step("race.rd0", 4'd1, 4'b0000, 8'd1, 0, 0, 0);
    for (int k = 0; k < TIMEOUT - 1; k++) step("race.wait", 4'd1, 4'b0000, 8'd1, 0, 0, 0);
    step("race.done", 4'd1, 4'b0000, 8'd1, 1, 1, 0);
    check("race.fin", 32'(bus.CP_IN_DDR_READ_Finish), 32'd1);
    check("race.terr", 32'(bus.timeout_err), 32'd0);

    // Main FSM idling mid-fetch does not abort; FINISH then returns to WAIT.
    step("abort.adv", 4'd3, 4'b0000, 8'd2, 0, 0, 0);
    fetch("abort", 4'd0, 4'b0000, 8'd2, 2, 1);
    step("abort.idle", 4'd0, 4'b0000, 8'd2, 0, 0, 0);
    check("abort.wait", 32'(bus.CP_IN_WAIT), 32'd1);

    // Reset during READ abandons the fetch and restores channel-0 priority.
    do_reset("rst5");
    step("mid.go", 4'd2, 4'b0101, 8'd4, 0, 0, 0);
    step("mid.pre", 4'd1, 4'b0101, 8'd4, 0, 0, 0);
    check("mid.ch1", 32'(bus.rd_ch), 32'd1);
    step("mid.rd0", 4'd1, 4'b0101, 8'd4, 0, 0, 0);
    step("mid.b1", 4'd1, 4'b0101, 8'd4, 1, 0, 0);
    step("mid.b2", 4'd1, 4'b0101, 8'd4, 1, 0, 0);
    do_reset("mid.rst");
    step("mid.go2", 4'd2, 4'b0000, 8'd4, 0, 0, 0);
    check("mid.first_edge", 32'(bus.CP_IN_Check_Empty), 32'd1);
    step("mid.pre2", 4'd1, 4'b0000, 8'd4, 0, 0, 0);
    check("mid.ch0", 32'(bus.rd_ch), 32'd0);

    // Random traffic against the model.
    do_reset("rst6");
    for (int i = 0; i < 3000; i++) begin
      step("rnd", 4'($urandom_range(0, 3)), 4'($urandom), 8'($urandom_range(0, 5)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/cp_fetch_scheduler.md
CP_FETCH_SCHEDULER -- requirements
Module: cp_fetch_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of event FIFO channels (2..16).
REQ-002 SHALL have parameter BLEN_W, default 8, meaning the burst-length width.
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of cycles in READ before an error is raised.
REQ-004 SHALL have local CH_W = clog2(NUM_CH) and TO_W = clog2(TIMEOUT+1).
REQ-005 SHALL use one clock and an asynchronous active-low reset: CLK  in  1  clock; RST_N  in  1  async active-low reset.
REQ-006 Main_FSM_state  in  4  main controller state (2 = start, 3 = advance, 0 = idle/abort).
REQ-007 event_fifo_empty  in  NUM_CH  per-channel empty flags.
REQ-008 burst_len_cfg  in  BLEN_W  requested beats per fetch.
REQ-009 rd_beat  in  1  one DDR beat accepted this cycle.
REQ-010 RD_Done  in  1  DDR read complete (single-cycle pulse).
REQ-011 err_clr  in  1  clears the error state and the sticky flags.
REQ-012 rd_req  out  1  one-cycle read request.
REQ-013 rd_ch  out  CH_W  granted channel index.
REQ-014 rd_len  out  BLEN_W  latched burst length.
REQ-015 beat_cnt  out  BLEN_W  beats received in the current fetch.
REQ-016 CP_IN_WAIT, CP_IN_Check_Empty, CP_IN_DDR_PRE, CP_IN_DDR_READ, CP_IN_DDR_READ_Finish, CP_IN_ERR  out  1 each  one-hot state flags.
REQ-017 timeout_err, len_err  out  1 each  sticky error flags.

Function
REQ-018 SHALL implement the states WAIT, CHECK, PRE, READ, FINISH and ERR; any illegal encoding SHALL go to WAIT on the next cycle.
REQ-019 WAIT SHALL go to CHECK when Main_FSM_state==2, and otherwise hold.
REQ-020 CHECK, with any event_fifo_empty bit low, SHALL go to PRE and latch the round-robin grant into rd_ch.
REQ-021 In CHECK, the grant SHALL be the first non-empty channel searching upward from (last_grant+1) mod NUM_CH.
REQ-022 last_grant SHALL reset to NUM_CH-1, so channel 0 has first priority.
REQ-023 last_grant SHALL update only on a CHECK->PRE transition.
REQ-024 CHECK with all channels empty SHALL go to WAIT if Main_FSM_state==0, and otherwise hold; a non-empty channel SHALL take priority over Main_FSM_state==0.
REQ-025 PRE SHALL last exactly one cycle: rd_req=1, rd_len=burst_len_cfg latched (a value of 0 latched as 1), beat_cnt cleared to 0, timeout counter cleared; next state READ.
REQ-026 READ SHALL increment beat_cnt on each rd_beat, saturating at all-ones, and SHALL increment the timeout counter every cycle.
REQ-027 READ with RD_Done SHALL go to FINISH; an rd_beat in the same cycle as RD_Done SHALL be counted.
REQ-028 On RD_Done, len_err SHALL be set if the final beat count != rd_len.
REQ-029 READ without RD_Done, with the timeout counter == TIMEOUT-1, SHALL go to ERR and set timeout_err; RD_Done in that same cycle SHALL win (go to FINISH, no error).
REQ-030 Main_FSM_state==0 SHALL NOT abort PRE or READ; the DDR transaction always completes.
REQ-031 FINISH SHALL go to CHECK when Main_FSM_state==3, go to WAIT when it is 0, and otherwise hold.
REQ-032 ERR SHALL hold until err_clr, then go to WAIT.
REQ-033 err_clr SHALL clear timeout_err and len_err in any state; a set event in the same cycle SHALL win over the clear.
REQ-034 rd_ch, rd_len and beat_cnt SHALL hold their values outside PRE/READ.
REQ-035 The CP_IN_* flags SHALL be decoded combinationally from the state register; exactly one SHALL be high at any time.

Reset
REQ-036 RST_N low SHALL asynchronously force: state=WAIT, rd_req=0, rd_ch=0, rd_len=0, beat_cnt=0, timeout counter=0, timeout_err=0, len_err=0, last_grant=NUM_CH-1.
REQ-037 Reset asserted mid-READ SHALL abandon the fetch; no error flag SHALL be set.
REQ-038 The first state transition after reset release SHALL occur on the first CLK edge with RST_N high.

Verification
REQ-039 SHALL cover: Main=2, event_fifo_empty=4'b1010, burst_len_cfg=4 -> PRE with rd_ch=0, rd_len=4; 4 beats then RD_Done -> FINISH, len_err=0.
REQ-040 SHALL cover: all channels non-empty, three consecutive fetches (Main=3 after each FINISH) -> rd_ch = 0,1,2 in that order.
REQ-041 SHALL cover: burst_len_cfg=0 -> rd_len=1; 3 beats then RD_Done -> len_err=1, which stays set until err_clr.
REQ-042 SHALL cover: TIMEOUT=16, no RD_Done -> ERR entered 16 cycles after READ entry with timeout_err=1; err_clr -> WAIT and the flag cleared.
REQ-043 SHALL cover: RD_Done on the timeout cycle -> FINISH, timeout_err=0; Main=0 during READ -> fetch completes, then FINISH->WAIT.
REQ-044 SHALL cover: RST_N pulsed low mid-READ -> all outputs at reset values immediately; next fetch grants channel 0.
